// File: rtl/memory_pkg.sv
// Shared memory-side definitions: command encodings and the buffer FSM
// state type, common to the word line buffer and the memory gateway.
package memory_pkg;

  typedef logic [1:0] mem_cmd_t;

  localparam mem_cmd_t CMD_READ       = 2'd0;
  localparam mem_cmd_t CMD_WRITE      = 2'd1;
  localparam mem_cmd_t CMD_WRITE_BACK = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/word_line_buffer.sv
// Single-line word buffer between a core and a line-wide memory gateway.
// Core side: start/wen/addr/wdata/flush in; rdata/done/idle out.
// Memory side: mem_cmd/mem_start/mem_wline/mem_raddr/mem_waddr out;
// mem_rline/mem_done/mem_idle in. Define WORD_LINE_BUFFER_STATS_EN to
// add hit_count/miss_count outputs.
module word_line_buffer
  import memory_pkg::*;
#(
  parameter int CACHE_LINE_WIDTH = 256,
  parameter int DATA_WIDTH       = 16,
  parameter int ADDR_WIDTH       = 64
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        wen,
  input  logic [ADDR_WIDTH-1:0]       addr,
  input  logic [DATA_WIDTH-1:0]       wdata,
  input  logic                        flush,
  output logic [DATA_WIDTH-1:0]       rdata,
  output logic                        done,
  output logic                        idle,
  output logic [1:0]                  mem_cmd,
  output logic                        mem_start,
  output logic [CACHE_LINE_WIDTH-1:0] mem_wline,
  output logic [64:0]                 mem_raddr,
  output logic [64:0]                 mem_waddr,
  input  logic [CACHE_LINE_WIDTH-1:0] mem_rline,
  input  logic                        mem_done,
  input  logic                        mem_idle
`ifdef WORD_LINE_BUFFER_STATS_EN
  ,
  output logic [31:0]                 hit_count,
  output logic [31:0]                 miss_count
`endif
);

  localparam int WPL   = CACHE_LINE_WIDTH / DATA_WIDTH;
  localparam int IDX_W = $clog2(WPL);
  localparam int TAG_W = ADDR_WIDTH - IDX_W;

  state_t                      state_q, state_d;
  logic                        valid_q, valid_d;
  logic                        dirty_q, dirty_d;
  logic [TAG_W-1:0]            tag_q, tag_d;
  logic [CACHE_LINE_WIDTH-1:0] line_q, line_d;
  logic [DATA_WIDTH-1:0]       rdata_q, rdata_d;
  mem_cmd_t                    cmd_q, cmd_d;
  logic [64:0]                 raddr_q, raddr_d;
  logic [64:0]                 waddr_q, waddr_d;
  logic [CACHE_LINE_WIDTH-1:0] wline_q, wline_d;
  logic [ADDR_WIDTH-1:0]       req_addr_q, req_addr_d;
  logic                        req_wen_q, req_wen_d;
  logic [DATA_WIDTH-1:0]       req_wdata_q, req_wdata_d;

  logic [TAG_W-1:0] in_tag, req_tag;
  int unsigned      in_off, req_off;
  logic             hit;

  assign in_tag  = addr[ADDR_WIDTH-1:IDX_W];
  assign req_tag = req_addr_q[ADDR_WIDTH-1:IDX_W];
  assign in_off  = 32'(addr[IDX_W-1:0]) * DATA_WIDTH;
  assign req_off = 32'(req_addr_q[IDX_W-1:0]) * DATA_WIDTH;
  assign hit     = valid_q && (tag_q == in_tag);

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    dirty_d     = dirty_q;
    tag_d       = tag_q;
    line_d      = line_q;
    rdata_d     = rdata_q;
    cmd_d       = cmd_q;
    raddr_d     = raddr_q;
    waddr_d     = waddr_q;
    wline_d     = wline_q;
    req_addr_d  = req_addr_q;
    req_wen_d   = req_wen_q;
    req_wdata_d = req_wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          req_addr_d  = addr;
          req_wen_d   = wen;
          req_wdata_d = wdata;
          if (hit) begin
            state_d = S_DONE;
            if (wen) begin
              line_d[in_off +: DATA_WIDTH] = wdata;
              dirty_d = 1'b1;
            end else begin
              rdata_d = line_q[in_off +: DATA_WIDTH];
            end
          end else begin
            state_d = S_ISSUE;
            raddr_d = 65'(in_tag);
            // A dirty victim is written back in the same transaction.
            cmd_d   = dirty_q ? CMD_WRITE_BACK : CMD_READ;
            waddr_d = dirty_q ? 65'(tag_q) : '0;
            wline_d = dirty_q ? line_q : '0;
          end
        end else if (flush) begin
          if (dirty_q) begin
            state_d = S_ISSUE;
            cmd_d   = CMD_WRITE;
            raddr_d = '0;
            waddr_d = 65'(tag_q);
            wline_d = line_q;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_ISSUE: begin
        if (mem_idle) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_done) begin
          state_d = S_DONE;
          if (cmd_q == CMD_WRITE) begin
            dirty_d = 1'b0;
          end else begin
            line_d  = mem_rline;
            tag_d   = req_tag;
            valid_d = 1'b1;
            dirty_d = 1'b0;
            if (req_wen_q) begin
              line_d[req_off +: DATA_WIDTH] = req_wdata_q;
              dirty_d = 1'b1;
            end else begin
              rdata_d = mem_rline[req_off +: DATA_WIDTH];
            end
          end
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      valid_q <= 1'b0;
      dirty_q <= 1'b0;
      rdata_q <= '0;
      cmd_q   <= CMD_READ;
      raddr_q <= '0;
      waddr_q <= '0;
      wline_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      rdata_q <= rdata_d;
      cmd_q   <= cmd_d;
      raddr_q <= raddr_d;
      waddr_q <= waddr_d;
      wline_q <= wline_d;
    end
  end

  always_ff @(posedge clock) begin
    tag_q       <= tag_d;
    line_q      <= line_d;
    req_addr_q  <= req_addr_d;
    req_wen_q   <= req_wen_d;
    req_wdata_q <= req_wdata_d;
  end

  // Memory request fields are only meaningful while issuing.
  assign mem_start = (state_q == S_ISSUE) && mem_idle;
  assign mem_cmd   = (state_q == S_ISSUE) ? cmd_q : '0;
  assign mem_raddr = (state_q == S_ISSUE) ? raddr_q : '0;
  assign mem_waddr = (state_q == S_ISSUE) ? waddr_q : '0;
  assign mem_wline = (state_q == S_ISSUE) ? wline_q : '0;
  assign rdata     = rdata_q;
  assign done      = (state_q == S_DONE);
  assign idle      = (state_q == S_IDLE);

`ifdef WORD_LINE_BUFFER_STATS_EN
  logic [31:0] hit_q, hit_d, miss_q, miss_d;

  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (state_q == S_IDLE && start) begin
      if (hit) hit_d = hit_q + 32'd1;
      else     miss_d = miss_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_word_line_buffer.sv
// Directed self-checking bench for word_line_buffer.
// Memory replies are modelled as word i of line L = {L[7:0], i[7:0]}.
module tb_word_line_buffer;

  logic         clock = 1'b0;
  logic         reset;
  logic         start, wen, flush;
  logic [63:0]  addr;
  logic [15:0]  wdata;
  logic [15:0]  rdata;
  logic         done, idle;
  logic [1:0]   mem_cmd;
  logic         mem_start;
  logic [255:0] mem_wline;
  logic [64:0]  mem_raddr, mem_waddr;
  logic [255:0] mem_rline;
  logic         mem_done, mem_idle;
`ifdef WORD_LINE_BUFFER_STATS_EN
  logic [31:0]  hit_count, miss_count;
`endif

  int checks = 0;
  int failures = 0;
  int nstart = 0;
  int n0;

  always #5 clock = ~clock;

  always @(negedge clock) if (mem_start === 1'b1) nstart++;

  word_line_buffer dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .wen       (wen),
    .addr      (addr),
    .wdata     (wdata),
    .flush     (flush),
    .rdata     (rdata),
    .done      (done),
    .idle      (idle),
    .mem_cmd   (mem_cmd),
    .mem_start (mem_start),
    .mem_wline (mem_wline),
    .mem_raddr (mem_raddr),
    .mem_waddr (mem_waddr),
    .mem_rline (mem_rline),
    .mem_done  (mem_done),
    .mem_idle  (mem_idle)
`ifdef WORD_LINE_BUFFER_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  function automatic logic [255:0] line_of(logic [7:0] l);
    logic [255:0] r;
    for (int i = 0; i < 16; i++) r[i*16 +: 16] = {l, 8'(i)};
    return r;
  endfunction

  task automatic chk(string tag, logic [255:0] obs, logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start (or flush) for one cycle; returns at the negedge after
  // the request was sampled.
  task automatic req(logic s, logic f, logic w, logic [63:0] a,
                     logic [15:0] d);
    @(negedge clock);
    start = s; flush = f; wen = w; addr = a; wdata = d;
    @(negedge clock);
    start = 0; flush = 0; wen = 0;
  endtask

  // Called in S_ISSUE with mem_start seen: move to S_WAIT, answer with
  // line l, and return at the negedge where S_DONE is visible.
  task automatic respond(logic [7:0] l);
    @(negedge clock);
    chk("wait_no_start", 256'(mem_start), 256'(0));
    chk("wait_cmd_zero", 256'(mem_cmd), 256'(0));
    mem_done = 1; mem_rline = line_of(l);
    @(negedge clock);
    mem_done = 0; mem_rline = '0;
  endtask

  initial begin
    reset = 1; start = 0; flush = 0; wen = 0; addr = '0; wdata = '0;
    mem_rline = '0; mem_done = 0; mem_idle = 1;
    repeat (2) @(negedge clock);
    chk("rst_idle", 256'(idle), 256'(1));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_mem_start", 256'(mem_start), 256'(0));
    chk("rst_mem_cmd", 256'(mem_cmd), 256'(0));
    chk("rst_rdata", 256'(rdata), 256'(0));
    reset = 0;

    // Cold load 0x25: READ of line 2, word 5.
    req(1, 0, 0, 64'h25, 16'h0);
    chk("ld25_start", 256'(mem_start), 256'(1));
    chk("ld25_cmd", 256'(mem_cmd), 256'(0));
    chk("ld25_raddr", 256'(mem_raddr), 256'(2));
    respond(8'h02);
    chk("ld25_done", 256'(done), 256'(1));
    chk("ld25_rdata", 256'(rdata), 256'(16'h0205));
    @(negedge clock);
    chk("ld25_done_low", 256'(done), 256'(0));
    chk("ld25_idle", 256'(idle), 256'(1));

    // Store hit then load hit on 0x23.
    n0 = nstart;
    req(1, 0, 1, 64'h23, 16'hBEEF);
    chk("st23_done", 256'(done), 256'(1));
    chk("st23_nostart", 256'(mem_start), 256'(0));
    req(1, 0, 0, 64'h23, 16'h0);
    chk("ld23_done", 256'(done), 256'(1));
    chk("ld23_rdata", 256'(rdata), 256'(16'hBEEF));
    @(negedge clock);
    chk("hit_nstart", 256'(nstart - n0), 256'(0));

    // Dirty miss on 0x40: write back line 2, read line 4.
    req(1, 0, 0, 64'h40, 16'h0);
    chk("wb_start", 256'(mem_start), 256'(1));
    chk("wb_cmd", 256'(mem_cmd), 256'(2));
    chk("wb_waddr", 256'(mem_waddr), 256'(2));
    chk("wb_raddr", 256'(mem_raddr), 256'(4));
    chk("wb_word3", 256'(mem_wline[3*16 +: 16]), 256'(16'hBEEF));
    chk("wb_word5", 256'(mem_wline[5*16 +: 16]), 256'(16'h0205));
    respond(8'h04);
    chk("ld40_rdata", 256'(rdata), 256'(16'h0400));
    @(negedge clock);

    // Store miss on 0x23 (clean victim) makes line 2 dirty again.
    req(1, 0, 1, 64'h23, 16'hCAFE);
    chk("st23m_cmd", 256'(mem_cmd), 256'(0));
    chk("st23m_raddr", 256'(mem_raddr), 256'(2));
    respond(8'h02);
    chk("st23m_rdata_held", 256'(rdata), 256'(16'h0400));
    @(negedge clock);

    // Flush dirty line -> WRITE; second flush completes without memory.
    req(0, 1, 0, 64'h0, 16'h0);
    chk("fl_start", 256'(mem_start), 256'(1));
    chk("fl_cmd", 256'(mem_cmd), 256'(1));
    chk("fl_waddr", 256'(mem_waddr), 256'(2));
    chk("fl_word3", 256'(mem_wline[3*16 +: 16]), 256'(16'hCAFE));
    respond(8'h00);
    chk("fl_done", 256'(done), 256'(1));
    @(negedge clock);
    n0 = nstart;
    req(0, 1, 0, 64'h0, 16'h0);
    chk("fl2_done", 256'(done), 256'(1));
    chk("fl2_nostart", 256'(mem_start), 256'(0));
    @(negedge clock);
    chk("fl2_nstart", 256'(nstart - n0), 256'(0));
    req(1, 0, 0, 64'h23, 16'h0);
    chk("fl_kept_data", 256'(rdata), 256'(16'hCAFE));
    @(negedge clock);

    // Memory busy: hold off mem_start for 10 cycles.
    n0 = nstart;
    mem_idle = 0;
    req(1, 0, 0, 64'h55, 16'h0);
    repeat (10) begin
      chk("busy_nostart", 256'(mem_start), 256'(0));
      @(negedge clock);
    end
    chk("busy_still_issue", 256'(nstart - n0), 256'(0));
    mem_idle = 1;
    #1;
    chk("busy_start", 256'(mem_start), 256'(1));
    chk("busy_raddr", 256'(mem_raddr), 256'(5));
    respond(8'h05);
    chk("busy_rdata", 256'(rdata), 256'(16'h0505));
    @(negedge clock);
    chk("busy_one_pulse", 256'(nstart - n0), 256'(1));

    // Reset while waiting on memory abandons the transaction.
    req(1, 0, 0, 64'h70, 16'h0);
    chk("rw_start", 256'(mem_start), 256'(1));
    @(negedge clock);
    chk("rw_in_wait", 256'(idle), 256'(0));
    reset = 1;
    @(negedge clock);
    reset = 0;
    chk("rw_idle", 256'(idle), 256'(1));
    chk("rw_done", 256'(done), 256'(0));
    chk("rw_rdata", 256'(rdata), 256'(0));
    req(1, 0, 0, 64'h55, 16'h0);
    chk("rw_invalid_miss", 256'(mem_start), 256'(1));
    chk("rw_cmd_read", 256'(mem_cmd), 256'(0));
    respond(8'h05);
    @(negedge clock);
    req(1, 0, 0, 64'h23, 16'h0);
    chk("rw_ld23_start", 256'(mem_start), 256'(1));
    chk("rw_ld23_raddr", 256'(mem_raddr), 256'(2));
    respond(8'h02);
    chk("rw_ld23_rdata", 256'(rdata), 256'(16'h0203));
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
